line_rasterizer: RTL and testbench

LINE_RASTERIZER -- requirements
Module: line_rasterizer

---
 rtl/line_pkg.sv | 22 ++
 rtl/line_rasterizer.sv | 146 ++++++++++++++
 tb/tb_line_rasterizer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/line_pkg.sv
// Shared definitions for the line rasterizer: coordinate and error-term
// width derivation plus the controller state encoding.
package line_pkg;

    // Bits needed to hold a coordinate in [0, n-1].
    function automatic int coord_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed error/delta width: the wider coordinate plus sign and headroom
    // so dx+dy and 2*err never wrap for representable endpoints.
    function automatic int err_width(input int xw, input int yw);
        return ((xw > yw) ? xw : yw) + 2;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_PLOT  = 2'd2
    } state_t;

endpackage

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: accepts two endpoints, emits one pixel per
// accepted framebuffer handshake from (x1,y1) to (x2,y2) inclusive.
// Optional build macro LINE_RASTERIZER_CLIP_EN suppresses writes of pixels
// outside the active area; such pixels are stepped over without a handshake.
module line_rasterizer
    import line_pkg::*;
#(
    parameter int  HOR_ACTIVE_PIXELS = 640,
    parameter int  VER_ACTIVE_PIXELS = 480,
    localparam int X_WIDTH   = coord_width(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH   = coord_width(VER_ACTIVE_PIXELS),
    localparam int ERR_WIDTH = err_width(X_WIDTH, Y_WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               ready,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [Y_WIDTH-1:0] y1,
    input  logic [X_WIDTH-1:0] x2,
    input  logic [Y_WIDTH-1:0] y2,
    output logic [X_WIDTH-1:0] pixel_x,
    output logic [Y_WIDTH-1:0] pixel_y,
    output logic               pixel_write,
    input  logic               pixel_ready
);

    state_t                      r_state = S_IDLE;
    state_t                      w_state_next;
    logic        [X_WIDTH-1:0]   r_x     = '0;
    logic        [Y_WIDTH-1:0]   r_y     = '0;
    logic        [X_WIDTH-1:0]   r_x_end = '0;
    logic        [Y_WIDTH-1:0]   r_y_end = '0;
    logic signed [ERR_WIDTH-1:0] r_dx    = '0;
    logic signed [ERR_WIDTH-1:0] r_dy    = '0;
    logic signed [ERR_WIDTH-1:0] r_err   = '0;
    logic                        r_sx_neg = 1'b0;
    logic                        r_sy_neg = 1'b0;

    logic signed [ERR_WIDTH-1:0] w_x_s, w_y_s, w_xe_s, w_ye_s;
    logic signed [ERR_WIDTH-1:0] w_dx_diff, w_dy_diff, w_dx_abs, w_dy_neg;
    logic signed [ERR_WIDTH:0]   w_e2, w_dx_ext, w_dy_ext;
    logic signed [ERR_WIDTH-1:0] w_add_x, w_add_y, w_err_next;
    logic                        w_step_x, w_step_y;
    logic                        w_visible, w_adv, w_last;

    // Endpoint deltas, evaluated in SETUP from the latched endpoints.
    assign w_x_s     = ERR_WIDTH'(r_x);
    assign w_y_s     = ERR_WIDTH'(r_y);
    assign w_xe_s    = ERR_WIDTH'(r_x_end);
    assign w_ye_s    = ERR_WIDTH'(r_y_end);
    assign w_dx_diff = w_xe_s - w_x_s;
    assign w_dy_diff = w_ye_s - w_y_s;
    assign w_dx_abs  = (w_dx_diff < 0) ? -w_dx_diff : w_dx_diff;
    assign w_dy_neg  = (w_dy_diff < 0) ? w_dy_diff : -w_dy_diff;

    // Step decision: e2 carries one extra bit so doubling never wraps.
    assign w_e2       = {r_err, 1'b0};
    assign w_dx_ext   = {r_dx[ERR_WIDTH-1], r_dx};
    assign w_dy_ext   = {r_dy[ERR_WIDTH-1], r_dy};
    assign w_step_x   = (w_e2 >= w_dy_ext);
    assign w_step_y   = (w_e2 <= w_dx_ext);
    assign w_add_x    = w_step_x ? r_dy : '0;
    assign w_add_y    = w_step_y ? r_dx : '0;
    assign w_err_next = r_err + w_add_x + w_add_y;

`ifdef LINE_RASTERIZER_CLIP_EN
    assign w_visible = (int'(r_x) < HOR_ACTIVE_PIXELS) && (int'(r_y) < VER_ACTIVE_PIXELS);
`else
    assign w_visible = 1'b1;
`endif

    // Cursor advances on a handshake, or immediately for a clipped pixel.
    assign w_adv  = (r_state == S_PLOT) && (!w_visible || pixel_ready);
    assign w_last = (r_x == r_x_end) && (r_y == r_y_end);

    assign pixel_x = r_x;
    assign pixel_y = r_y;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        pixel_write  = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) w_state_next = S_SETUP;
            end
            S_SETUP: w_state_next = S_PLOT;
            S_PLOT: begin
                pixel_write = w_visible;
                if (w_adv && w_last) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Endpoint latch, delta setup and Bresenham cursor/error update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_x_end  <= '0;
            r_y_end  <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x     <= x1;
                        r_y     <= y1;
                        r_x_end <= x2;
                        r_y_end <= y2;
                    end
                end
                S_SETUP: begin
                    r_dx     <= w_dx_abs;
                    r_dy     <= w_dy_neg;
                    r_err    <= w_dx_abs + w_dy_neg;
                    r_sx_neg <= (w_dx_diff < 0);
                    r_sy_neg <= (w_dy_diff < 0);
                end
                S_PLOT: begin
                    if (w_adv && !w_last) begin
                        r_err <= w_err_next;
                        if (w_step_x) r_x <= r_sx_neg ? r_x - X_WIDTH'(1) : r_x + X_WIDTH'(1);
                        if (w_step_y) r_y <= r_sy_neg ? r_y - Y_WIDTH'(1) : r_y + Y_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_rasterizer.sv
// Scoreboard bench for line_rasterizer: expected pixels are queued when a
// line is requested and compared as the DUT hands pixels to the framebuffer.
module tb_line_rasterizer;

    localparam int HOR = 640;
    localparam int VER = 480;
    localparam int XW  = 10;
    localparam int YW  = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          ready;
    logic [XW-1:0] x1 = '0, x2 = '0;
    logic [YW-1:0] y1 = '0, y2 = '0;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic          pixel_write;
    logic          pixel_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int exp_x[$];
    int exp_y[$];
    bit stall_mode = 1'b0;
    int stall_cnt = 0;
    bit stalled = 1'b0;
    int hold_x = 0, hold_y = 0;

    line_rasterizer #(.HOR_ACTIVE_PIXELS(HOR), .VER_ACTIVE_PIXELS(VER)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_write(pixel_write), .pixel_ready(pixel_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_px(input int x, input int y);
`ifdef LINE_RASTERIZER_CLIP_EN
        if (x >= HOR || y >= VER) return;
`endif
        exp_x.push_back(x);
        exp_y.push_back(y);
    endtask

    // Reference integer Bresenham, both endpoints included.
    task automatic model_line(input int ax, input int ay, input int bx, input int by);
        int dx, dy, sx, sy, err, e2, x, y;
        dx = (bx > ax) ? bx - ax : ax - bx;
        dy = (by > ay) ? ay - by : by - ay;
        sx = (bx >= ax) ? 1 : -1;
        sy = (by >= ay) ? 1 : -1;
        err = dx + dy;
        x = ax;
        y = ay;
        forever begin
            push_px(x, y);
            if (x == bx && y == by) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // Framebuffer side: always ready, or three stall cycles per pixel.
    always @(posedge clk) begin
        #1;
        if (!stall_mode) begin
            pixel_ready = 1'b1;
        end else if (pixel_write) begin
            pixel_ready = (stall_cnt == 3);
            stall_cnt   = (stall_cnt == 3) ? 0 : stall_cnt + 1;
        end else begin
            pixel_ready = 1'b0;
            stall_cnt   = 0;
        end
    end

    // Monitor: stall stability and scoreboard pop on each transfer.
    always @(negedge clk) begin
        if (stalled) begin
            check("stall_write", int'(pixel_write), 1);
            check("stall_x", int'(pixel_x), hold_x);
            check("stall_y", int'(pixel_y), hold_y);
        end
        stalled = pixel_write && !pixel_ready;
        hold_x  = int'(pixel_x);
        hold_y  = int'(pixel_y);
        if (pixel_write && pixel_ready) begin
            if (exp_x.size() == 0) begin
                check("extra_pixel_x", int'(pixel_x), -1);
            end else begin
                check("pixel_x", int'(pixel_x), exp_x.pop_front());
                check("pixel_y", int'(pixel_y), exp_y.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int i;
        for (i = 0; i < 100; i++) begin
            if (ready) break;
            @(posedge clk); #1;
        end
        check("ready_wait", int'(i < 100), 1);
    endtask

    task automatic start_line(input int ax, input int ay, input int bx, input int by);
        wait_ready();
        x1 = XW'(ax); y1 = YW'(ay); x2 = XW'(bx); y2 = YW'(by);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_x.size() == 0 && ready) break;
            @(posedge clk); #1;
        end
        check("line_done", int'(i < budget), 1);
        repeat (3) begin @(posedge clk); #1; end
        check("leftover", exp_x.size(), 0);
    endtask

    task automatic run_model(input int ax, input int ay, input int bx, input int by);
        model_line(ax, ay, bx, by);
        start_line(ax, ay, bx, by);
        wait_done(2000);
    endtask

    initial begin
        // Power-up values before any reset.
        #1;
        check("init_ready", int'(ready), 1);
        check("init_write", int'(pixel_write), 0);
        check("init_x", int'(pixel_x), 0);
        check("init_y", int'(pixel_y), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", int'(ready), 1);
        check("rst_write", int'(pixel_write), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Horizontal line, cycle-accurate latency and throughput.
        for (int i = 0; i < 4; i++) push_px(i, 0);
        start_line(0, 0, 3, 0);
        check("setup_write", int'(pixel_write), 0);
        check("setup_ready", int'(ready), 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("plot_write", int'(pixel_write), 1);
        end
        @(posedge clk); #1;
        check("end_write", int'(pixel_write), 0);
        check("end_ready", int'(ready), 1);
        wait_done(10);

        // Steep line, leftward: ties in e2>=dy step x on the first move.
        push_px(5, 5); push_px(4, 6); push_px(4, 7); push_px(3, 8); push_px(3, 9);
        start_line(5, 5, 3, 9);
        wait_done(20);

        // Single point; a start while busy must be ignored.
        push_px(7, 7);
        start_line(7, 7, 7, 7);
        x1 = 1; y1 = 1; x2 = 3; y2 = 3;
        start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(20);
        repeat (10) begin @(posedge clk); #1; end
        check("busy_start_ignored", exp_x.size(), 0);

        // Diagonal under framebuffer backpressure.
        stall_mode = 1'b1;
        model_line(0, 0, 2, 2);
        start_line(0, 0, 2, 2);
        wait_done(100);
        stall_mode = 1'b0;
        @(posedge clk); #1;

        // Reset while the second pixel is presented.
        push_px(0, 0); push_px(1, 0);
        start_line(0, 0, 9, 0);
        @(posedge clk); #1;
        check("abort_first_write", int'(pixel_write), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_write", int'(pixel_write), 0);
        check("abort_ready", int'(ready), 1);
        check("abort_x", int'(pixel_x), 0);
        check("abort_y", int'(pixel_y), 0);
        rst = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        check("abort_leftover", exp_x.size(), 0);

        // Line running off the right edge of the active area.
        run_model(637, 0, 642, 0);

        // Full-screen diagonals and random short lines.
        run_model(0, 0, 639, 479);
        run_model(639, 0, 0, 479);
        for (int n = 0; n < 8; n++) begin
            run_model(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                      int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
